// File: rtl/flicker_link_pkg.sv
// flicker_link_pkg: shared widths and TX state encoding for the flicker word link
package flicker_link_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} tx_state_e;
endpackage

// File: rtl/flicker_sync.sv
// flicker_sync: optional 2-flop synchroniser for one flicker input (FLICKER_SYNC_EN)
module flicker_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
`ifdef FLICKER_SYNC_EN
    logic [1:0] sync_q;
    // Two-stage capture of an asynchronous toggle level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
`endif
endmodule

// File: rtl/pulpino_flicker_word_link.sv
// pulpino_flicker_word_link: byte toggle-handshake <-> 32-bit word valid/ready bridge (FLICKER_SYNC_EN adds input synchronisers)
module pulpino_flicker_word_link
    import flicker_link_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int RX_TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_write_flicker_i,
    output logic        rx_read_flicker_o,
    output logic [31:0] rx_word_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        rx_timeout_o,
    input  logic [31:0] tx_word_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_write_flicker_o,
    input  logic        tx_read_flicker_i
);
    localparam int W  = BYTES_PER_WORD * BYTE_W;
    localparam int CW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TW = $clog2(RX_TIMEOUT);

    logic          rx_flk, tx_flk;
    logic          rx_seen_q, rx_ack_q, rx_valid_q, rx_tmo_pulse_q;
    logic [CW-1:0] rx_cnt_q;
    logic [TW-1:0] rx_tmo_q;
    logic [W-1:0]  rx_buf_q, rx_buf_d, rx_word_q;
    logic          rx_accept, rx_last, rx_expire;

    tx_state_e     tx_state_q;
    logic [W-1:0]  tx_sh_q;
    logic [CW-1:0] tx_idx_q;
    logic [7:0]    tx_data_q;
    logic          tx_wf_q, tx_ready_q;

    flicker_sync u_rx_sync (.clk(clk), .rst_n(rst_n), .d_i(rx_write_flicker_i), .q_o(rx_flk));
    flicker_sync u_tx_sync (.clk(clk), .rst_n(rst_n), .d_i(tx_read_flicker_i),  .q_o(tx_flk));

    // A byte is taken only when the output word slot is free or being drained this cycle
    assign rx_accept = (rx_flk != rx_seen_q) && (!rx_valid_q || rx_ready_i);
    assign rx_last   = rx_cnt_q == CW'(BYTES_PER_WORD - 1);
    assign rx_expire = !rx_accept && rx_cnt_q != '0 && rx_tmo_q == TW'(RX_TIMEOUT - 1);

    // Partial word with the incoming byte dropped into its lane
    always_comb begin
        rx_buf_d = rx_buf_q;
        rx_buf_d[int'(rx_cnt_q)*BYTE_W +: BYTE_W] = rx_data_i;
    end

    // RX: capture, ack toggle, word completion, idle timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_seen_q      <= 1'b0;
            rx_ack_q       <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_tmo_pulse_q <= 1'b0;
            rx_cnt_q       <= '0;
            rx_tmo_q       <= '0;
            rx_buf_q       <= '0;
            rx_word_q      <= '0;
        end else begin
            rx_tmo_pulse_q <= rx_expire;
            if (rx_accept) begin
                rx_buf_q  <= rx_buf_d;
                rx_seen_q <= rx_flk;
                rx_ack_q  <= ~rx_ack_q;
                rx_tmo_q  <= '0;
                rx_cnt_q  <= rx_last ? '0 : rx_cnt_q + 1'b1;
            end else if (rx_expire) begin
                rx_cnt_q <= '0;
                rx_tmo_q <= '0;
            end else if (rx_cnt_q != '0) begin
                rx_tmo_q <= rx_tmo_q + 1'b1;
            end
            if (rx_accept && rx_last) begin
                rx_word_q  <= rx_buf_d;
                rx_valid_q <= 1'b1;
            end else if (rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    // TX FSM: load word, present byte, toggle, wait for matching ack level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_sh_q    <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_wf_q    <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            case (tx_state_q)
                IDLE:
                    if (tx_valid_i && tx_ready_q) begin
                        tx_sh_q    <= tx_word_i >> BYTE_W;
                        tx_data_q  <= tx_word_i[BYTE_W-1:0];
                        tx_idx_q   <= '0;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= SEND;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                SEND: begin
                    tx_wf_q    <= ~tx_wf_q;
                    tx_state_q <= WAIT_ACK;
                end
                WAIT_ACK:
                    if (tx_flk == tx_wf_q) begin
                        if (tx_idx_q == CW'(BYTES_PER_WORD - 1)) begin
                            tx_ready_q <= 1'b1;
                            tx_state_q <= IDLE;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 1'b1;
                            tx_data_q  <= tx_sh_q[BYTE_W-1:0];
                            tx_sh_q    <= tx_sh_q >> BYTE_W;
                            tx_state_q <= SEND;
                        end
                    end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign rx_read_flicker_o  = rx_ack_q;
    assign rx_word_o          = rx_word_q;
    assign rx_valid_o         = rx_valid_q;
    assign rx_timeout_o       = rx_tmo_pulse_q;
    assign tx_ready_o         = tx_ready_q;
    assign tx_data_o          = tx_data_q;
    assign tx_write_flicker_o = tx_wf_q;
endmodule

// File: tb/tb_pulpino_flicker_word_link.sv
// tb_pulpino_flicker_word_link: randomized peer model for both directions of the flicker word link
module tb_pulpino_flicker_word_link;
`ifdef FLICKER_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int RXT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_write_flicker_i = 1'b0;
    logic        rx_read_flicker_o;
    logic [31:0] rx_word_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        rx_timeout_o;
    logic [31:0] tx_word_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_write_flicker_o;
    logic        tx_read_flicker_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pulpino_flicker_word_link #(.BYTES_PER_WORD(4), .RX_TIMEOUT(RXT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data_i(rx_data_i), .rx_write_flicker_i(rx_write_flicker_i),
        .rx_read_flicker_o(rx_read_flicker_o), .rx_word_o(rx_word_o),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_timeout_o(rx_timeout_o),
        .tx_word_i(tx_word_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_data_o(tx_data_o), .tx_write_flicker_o(tx_write_flicker_o),
        .tx_read_flicker_i(tx_read_flicker_i)
    );

    // Little-endian word from an ordered byte list
    function automatic logic [31:0] pack(input logic [7:0] b [4]);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w = w | (32'(b[i]) << (8 * i));
        return w;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] w, input int i);
        return 8'((w >> (8 * i)) & 32'hff);
    endfunction

    // Peer presents a byte by toggling, then waits for the matching ack level
    task automatic send_byte(input logic [7:0] b, input int exp_lat);
        int n;
        rx_data_i = b;
        rx_write_flicker_i = ~rx_write_flicker_i;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_read_flicker_o !== rx_write_flicker_i && n < 64);
        vectors++;
        if (rx_read_flicker_o !== rx_write_flicker_i || (exp_lat > 0 && n != exp_lat)) begin
            miscompares++;
            $display("FAIL rx_ack byte=%02h ack=%b want=%b latency=%0d required=%0d",
                     b, rx_read_flicker_o, rx_write_flicker_i, n, exp_lat);
        end
    endtask

    task automatic send_word(input logic [7:0] b [4]);
        for (int i = 0; i < 4; i++) begin
            send_byte(b[i], 1 + SYNC);
            vectors++;
            if (i < 3 && rx_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rx_valid_early lane=%0d got=%b required=0", i, rx_valid_o);
            end else if (i == 3 && (rx_valid_o !== 1'b1 || rx_word_o !== pack(b))) begin
                miscompares++;
                $display("FAIL rx_word got=%08h valid=%b required=%08h valid=1",
                         rx_word_o, rx_valid_o, pack(b));
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_read_flicker_o, rx_word_o, rx_valid_o, rx_timeout_o, tx_ready_o, tx_data_o,
             tx_write_flicker_o} !== 45'b0) begin
            miscompares++;
            $display("FAIL reset_outputs word=%08h valid=%b ack=%b tmo=%b rdy=%b data=%02h wf=%b required all 0",
                     rx_word_o, rx_valid_o, rx_read_flicker_o, rx_timeout_o, tx_ready_o, tx_data_o,
                     tx_write_flicker_o);
        end
        rst_n = 1'b1;
        rx_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_ready_o !== 1'b1 || rx_valid_o !== 1'b0 || tx_write_flicker_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset rdy=%b valid=%b wf=%b required 1 0 0",
                     tx_ready_o, rx_valid_o, tx_write_flicker_o);
        end
    endtask

    task automatic test_rx_basic;
        logic [7:0] b [4];
        b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_word(b);
        @(negedge clk);
        vectors++;
        if (rx_valid_o !== 1'b0 || rx_read_flicker_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_single_valid valid=%b ack=%b required 0 0", rx_valid_o, rx_read_flicker_o);
        end
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            send_word(b);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
    endtask

    task automatic test_rx_backpressure;
        logic [7:0] b [4];
        logic [31:0] held;
        logic ack0;
        bit bad;
        rx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        send_word(b);
        held = pack(b);
        ack0 = rx_read_flicker_o;
        b[0] = 8'($urandom);
        rx_data_i = b[0];
        rx_write_flicker_i = ~rx_write_flicker_i;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bad = bad | (rx_read_flicker_o !== ack0) | (rx_word_o !== held) | (rx_valid_o !== 1'b1);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rx_stall ack=%b required=%b word=%08h required=%08h valid=%b",
                     rx_read_flicker_o, ack0, rx_word_o, held, rx_valid_o);
        end
        rx_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (rx_read_flicker_o !== ~ack0 || rx_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_release ack=%b required=%b valid=%b required=0",
                     rx_read_flicker_o, ~ack0, rx_valid_o);
        end
        for (int i = 1; i < 4; i++) begin
            b[i] = 8'($urandom);
            send_byte(b[i], 1 + SYNC);
        end
        vectors++;
        if (rx_valid_o !== 1'b1 || rx_word_o !== pack(b)) begin
            miscompares++;
            $display("FAIL rx_after_stall word=%08h valid=%b required=%08h", rx_word_o, rx_valid_o, pack(b));
        end
        @(negedge clk);
    endtask

    task automatic test_rx_timeout;
        logic [7:0] b [4];
        int pulses, at;
        send_byte(8'($urandom), 1 + SYNC);
        send_byte(8'($urandom), 1 + SYNC);
        pulses = 0;
        at = 0;
        for (int n = 1; n <= RXT + 20; n++) begin
            @(negedge clk);
            if (rx_timeout_o === 1'b1) begin
                pulses++;
                at = n;
            end
        end
        vectors++;
        if (pulses != 1 || at != RXT) begin
            miscompares++;
            $display("FAIL rx_timeout pulses=%0d at=%0d required 1 at %0d", pulses, at, RXT);
        end
        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_word(b);
        @(negedge clk);
    endtask

    // Drive one TX word; the peer acks bytes below nack and stops at byte nack
    task automatic tx_word(input logic [31:0] w, input int dly, input int nack);
        int n;
        logic [7:0] held;
        bit moved;
        n = 0;
        while (tx_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (tx_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_ready_idle got=%b required=1", tx_ready_o);
            return;
        end
        tx_word_i = w;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
        tx_word_i = $urandom;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (tx_write_flicker_o === tx_read_flicker_i && n < 20) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (tx_write_flicker_o === tx_read_flicker_i || tx_data_o !== lane(w, i) || tx_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL tx_byte%0d data=%02h required=%02h ready=%b required=0 toggled=%b",
                         i, tx_data_o, lane(w, i), tx_ready_o, tx_write_flicker_o !== tx_read_flicker_i);
                return;
            end
            if (i == nack) return;
            held = tx_data_o;
            moved = 1'b0;
            repeat (dly < 0 ? int'($urandom_range(0, 4)) : dly) begin
                @(negedge clk);
                moved = moved | (tx_data_o !== held) | (tx_ready_o !== 1'b0);
            end
            vectors++;
            if (moved) begin
                miscompares++;
                $display("FAIL tx_hold%0d data=%02h required=%02h ready=%b required=0", i, tx_data_o, held, tx_ready_o);
            end
            tx_read_flicker_i = tx_write_flicker_o;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready_o !== 1'b1 && n < 20);
        vectors++;
        if (n != 1 + SYNC) begin
            miscompares++;
            $display("FAIL tx_ready_return cycles=%0d required=%0d", n, 1 + SYNC);
        end
    endtask

    task automatic test_tx;
        tx_word(32'h12345678, 3, 4);
        for (int k = 0; k < 8; k++) tx_word($urandom, -1, 4);
    endtask

    task automatic test_tx_reset;
        tx_word($urandom, -1, 2);
        #2;
        rst_n = 1'b0;
        tx_read_flicker_i = 1'b0;
        rx_write_flicker_i = 1'b0;
        #1;
        vectors++;
        if ({rx_read_flicker_o, rx_word_o, rx_valid_o, rx_timeout_o, tx_ready_o, tx_data_o,
             tx_write_flicker_o} !== 45'b0) begin
            miscompares++;
            $display("FAIL async_reset word=%08h valid=%b ack=%b rdy=%b data=%02h wf=%b required all 0",
                     rx_word_o, rx_valid_o, rx_read_flicker_o, tx_ready_o, tx_data_o, tx_write_flicker_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tx_word($urandom, -1, 4);
    endtask

    initial begin
        test_reset;
        test_rx_basic;
        test_rx_backpressure;
        test_rx_timeout;
        test_tx;
        test_tx_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pulpino_flicker_word_link.md
Name: pulpino_flicker_word_link

Overview:
Pulpino-side endpoint of the USB<->Pulpino byte channel. Consumes the 8-bit data plus toggle ("flicker") handshake that usb_pulpino_channel drives onto gpio_in, and reassembles the bytes into 32-bit words. In the other direction it serialises 32-bit words into bytes with the same toggle handshake toward usb_pulpino_channel. Sits between the GPIO pins of pulpino and a word-level valid/ready consumer/producer in the Pulpino system.

Parameters:
BYTES_PER_WORD, 4, bytes per assembled/serialised word; the word is BYTES_PER_WORD*8 bits wide.
RX_TIMEOUT, 1024, idle cycles after which a partially assembled RX word is discarded; minimum 2.

Ports:
clk  in  1  single system clock
rst_n  in  1  reset, asynchronous, active-low
rx_data_i  in  8  incoming byte from the channel
rx_write_flicker_i  in  1  toggles when the peer presents a new byte
rx_read_flicker_o  out  1  toggled by this block to acknowledge a captured byte
rx_word_o  out  32  assembled word, little-endian (first byte in [7:0])
rx_valid_o  out  1  rx_word_o valid
rx_ready_i  in  1  consumer accepts rx_word_o
rx_timeout_o  out  1  one-cycle pulse when a partial word is dropped
tx_word_i  in  32  word to send
tx_valid_i  in  1  tx_word_i valid
tx_ready_o  out  1  block can accept tx_word_i
tx_data_o  out  8  outgoing byte
tx_write_flicker_o  out  1  toggled when tx_data_o holds a new byte
tx_read_flicker_i  in  1  peer ack; a byte is acknowledged when it equals tx_write_flicker_o

Behaviour:
- Reset: all outputs 0; rx_seen=0, rx byte_cnt=0, timeout counter=0, TX state IDLE, tx_idx=0. A 1 on rx_write_flicker_i right after reset counts as a pending byte.
- RX new-byte condition: rx_write_flicker_i != rx_seen.
- RX accept: new byte AND (!rx_valid_o OR rx_ready_i). On accept, capture rx_data_i into byte lane byte_cnt, rx_seen <= rx_write_flicker_i, rx_read_flicker_o toggles at the same edge. An ack is never issued for a byte that is not captured.
- RX completion: accepting lane BYTES_PER_WORD-1 loads rx_word_o and sets rx_valid_o at that edge. byte_cnt wraps to 0. Latency is 1 cycle from toggle detection to ack/valid.
- rx_valid_o/rx_word_o hold until rx_valid_o && rx_ready_i. A simultaneous handshake and new-byte acceptance are both honoured.
- RX timeout: the counter increments each cycle while byte_cnt!=0 and no byte is accepted, and clears on accept. On reaching RX_TIMEOUT: byte_cnt<=0, counter<=0, rx_timeout_o=1 for one cycle. rx_valid_o is unaffected.
- TX FSM states:
  - IDLE: tx_ready_o=1. On tx_valid_i, latch the word, tx_idx<=0, tx_data_o<=byte0, go to SEND.
  - SEND: tx_ready_o=0; toggle tx_write_flicker_o (data was set up one cycle earlier); go to WAIT_ACK.
  - WAIT_ACK: tx_ready_o=0. On tx_read_flicker_i==tx_write_flicker_o: if tx_idx==BYTES_PER_WORD-1 go to IDLE; otherwise tx_idx++, tx_data_o<=next byte, go to SEND.
- tx_data_o holds stable from SEND until the ack.
- Mid-operation async reset: both directions abort immediately; partial words are lost; flicker levels return to 0. The peer shares the reset.

Optional Feature:
FLICKER_SYNC_EN
- Defined: rx_write_flicker_i and tx_read_flicker_i each pass through a 2-flop synchroniser (reset to 0) before comparison. rx_data_i is sampled on the cycle the synchronised toggle is detected; the peer holds the data until ack. This adds 2 cycles of latency per direction.
- Undefined: the inputs are compared directly, for a same-clock peer.

Decomposition:
- Package flicker_link_pkg: BYTE_W=8, WORD_W=32, tx_state_e {IDLE, SEND, WAIT_ACK}.
- Sub-module flicker_sync: optional 2-flop synchroniser on one flicker input, selected by FLICKER_SYNC_EN. It is instantiated twice.

Test Plan:
- RX bytes 0xEF,0xBE,0xAD,0xDE, each toggling rx_write_flicker_i after the ack, with rx_ready_i=1 -> rx_word_o=0xDEADBEEF, rx_valid_o for 1 cycle, 4 ack toggles, rx_read_flicker_o ends at 0.
- Hold rx_ready_i=0 after a full word, then send a 5th byte -> no ack toggle and word unchanged. Raise rx_ready_i -> handshake, the 5th byte is acked in the same cycle, byte_cnt=1.
- Send 2 bytes, then idle 1024 cycles -> rx_timeout_o pulses once. The next 4 bytes 0x01..0x04 yield 0x04030201.
- tx_word_i=0x12345678, peer acks 3 cycles after each toggle -> tx_data_o sequence 0x78,0x56,0x34,0x12. tx_ready_o stays low until the 4th ack.
- rst_n asserted in WAIT_ACK after 2 bytes -> all outputs 0 asynchronously. After release the next tx word is sent from byte0.
- With FLICKER_SYNC_EN, repeat the first scenario -> same word, each ack delayed 2 extra cycles.
